// File: rtl/stage_monitor.sv
// Pipeline stage monitor: sticky handshake flags, per-stage valid counters,
// first-valid to last-ready latency measurement, BRAM write capture and a readout mux.
module stage_monitor #(
    parameter int NUM_STAGES = 4,
    parameter int CNT_W      = 32,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_i,
    input  logic [NUM_STAGES-1:0]   vld_i,
    input  logic [NUM_STAGES-1:0]   rdy_i,
    input  logic                    cap_en_i,
    input  logic [ADDR_W-1:0]       cap_addr_i,
    input  logic [DATA_W-1:0]       cap_data_i,
    input  logic [ADDR_W-1:0]       match_addr_i,
    input  logic                    cap_mode_i,
    input  logic [7:0]              sel_i,
    output logic [31:0]             dbg_data_o,
    output logic [2*NUM_STAGES-1:0] flags_o,
    output logic                    busy_o,
    output logic                    cap_hit_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    logic [2*NUM_STAGES-1:0] flags_q, flags_d;
    logic [CNT_W-1:0]        cnt_q [NUM_STAGES];
    logic [CNT_W-1:0]        cnt_d [NUM_STAGES];
    logic [1:0]              state_q, state_d;
    logic [CNT_W-1:0]        lat_q, lat_d;
    logic                    busy_q, busy_d;
    logic [DATA_W-1:0]       cap_data_q, cap_data_d;
    logic                    cap_hit_q, cap_hit_d;
    logic [CNT_W-1:0]        hit_cnt_q, hit_cnt_d;
    logic [31:0]             dbg_q, dbg_d;
    logic                    hit_s;

    assign hit_s = cap_en_i && (cap_addr_i == match_addr_i);

    // Statistics next-state; a clear discards every event of its own cycle.
    always_comb begin
        flags_d    = flags_q;
        cnt_d      = cnt_q;
        state_d    = state_q;
        lat_d      = lat_q;
        cap_data_d = cap_data_q;
        cap_hit_d  = cap_hit_q;
        hit_cnt_d  = hit_cnt_q;
        if (clr_i) begin
            flags_d    = '0;
            for (int i = 0; i < NUM_STAGES; i++) begin
                cnt_d[i] = '0;
            end
            state_d    = ST_IDLE;
            lat_d      = '0;
            cap_data_d = '0;
            cap_hit_d  = 1'b0;
            hit_cnt_d  = '0;
        end else begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                flags_d[2*i+1] = flags_q[2*i+1] | vld_i[i];
                flags_d[2*i]   = flags_q[2*i]   | rdy_i[i];
                cnt_d[i]       = vld_i[i] ? sat_inc(cnt_q[i]) : cnt_q[i];
            end
            case (state_q)
                ST_IDLE: begin
                    if (vld_i[0]) begin
                        lat_d   = '0;
                        state_d = rdy_i[NUM_STAGES-1] ? ST_DONE : ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    lat_d   = sat_inc(lat_q);
                    state_d = rdy_i[NUM_STAGES-1] ? ST_DONE : ST_RUN;
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                    lat_d   = '0;
                end
            endcase
            // Mode 0 keeps only the first hit since the last clear.
            if (hit_s) begin
                cap_hit_d = 1'b1;
                hit_cnt_d = sat_inc(hit_cnt_q);
                if (cap_mode_i || !cap_hit_q) begin
                    cap_data_d = cap_data_i;
                end else begin
                    cap_data_d = cap_data_q;
                end
            end else begin
                cap_hit_d = cap_hit_q;
            end
        end
        busy_d = (state_d == ST_RUN);
    end

    // Readout word selection from current register state.
    always_comb begin
        dbg_d = 32'hDEAD_BEEF;
        case (sel_i)
            8'd0: dbg_d = {16'hDB61, 8'(CNT_W), 8'(NUM_STAGES)};
            8'd1: begin
                dbg_d = 32'd0;
                dbg_d[2*NUM_STAGES-1:0] = flags_q;
            end
            8'd2: begin
                dbg_d = 32'd0;
                dbg_d[CNT_W-1:0] = lat_q;
            end
            8'd3: begin
                dbg_d = 32'd0;
                dbg_d[DATA_W-1:0] = cap_data_q;
            end
            8'd4: begin
                dbg_d = 32'd0;
                dbg_d[CNT_W-1:0] = hit_cnt_q;
            end
            8'd5: dbg_d = {30'd0, state_q};
            default: begin
                for (int i = 0; i < NUM_STAGES; i++) begin
                    if (sel_i == 8'(16 + i)) begin
                        dbg_d = 32'd0;
                        dbg_d[CNT_W-1:0] = cnt_q[i];
                    end else begin
                        dbg_d = dbg_d;
                    end
                end
            end
        endcase
    end

    // State registers; reset also clears the readout word, clear does not.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q    <= '0;
            for (int i = 0; i < NUM_STAGES; i++) begin
                cnt_q[i] <= '0;
            end
            state_q    <= ST_IDLE;
            lat_q      <= '0;
            busy_q     <= 1'b0;
            cap_data_q <= '0;
            cap_hit_q  <= 1'b0;
            hit_cnt_q  <= '0;
            dbg_q      <= 32'd0;
        end else begin
            flags_q    <= flags_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            lat_q      <= lat_d;
            busy_q     <= busy_d;
            cap_data_q <= cap_data_d;
            cap_hit_q  <= cap_hit_d;
            hit_cnt_q  <= hit_cnt_d;
            dbg_q      <= dbg_d;
        end
    end

    assign dbg_data_o = dbg_q;
    assign flags_o    = flags_q;
    assign busy_o     = busy_q;
    assign cap_hit_o  = cap_hit_q;

endmodule

// File: tb/tb_stage_monitor.sv
// Bench for stage_monitor: directed scenarios on a default and an 8-bit-counter
// instance, checked each cycle against an event-level model plus literal pins.
module tb_stage_monitor;
    localparam int NS = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, clr_i, cap_en_i, cap_mode_i;
    logic [NS-1:0] vld_i, rdy_i;
    logic [15:0]   cap_addr_i, match_addr_i;
    logic [31:0]   cap_data_i;
    logic [7:0]    sel_i;

    logic [31:0]   dbg32, dbg8;
    logic [7:0]    flags32, flags8;
    logic          busy32, busy8, hit32, hit8;

    stage_monitor u_dut (
        .clk(clk), .rst(rst), .clr_i(clr_i), .vld_i(vld_i), .rdy_i(rdy_i),
        .cap_en_i(cap_en_i), .cap_addr_i(cap_addr_i), .cap_data_i(cap_data_i),
        .match_addr_i(match_addr_i), .cap_mode_i(cap_mode_i), .sel_i(sel_i),
        .dbg_data_o(dbg32), .flags_o(flags32), .busy_o(busy32), .cap_hit_o(hit32)
    );

    stage_monitor #(.CNT_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .clr_i(clr_i), .vld_i(vld_i), .rdy_i(rdy_i),
        .cap_en_i(cap_en_i), .cap_addr_i(cap_addr_i), .cap_data_i(cap_data_i),
        .match_addr_i(match_addr_i), .cap_mode_i(cap_mode_i), .sel_i(sel_i),
        .dbg_data_o(dbg8), .flags_o(flags8), .busy_o(busy8), .cap_hit_o(hit8)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Event-level model: unbounded counts, saturated only when read out.
    longint      cyc = 0;
    int          m_phase = 0;        // 0 idle, 1 measuring, 2 done
    longint      m_start = 0, m_stop = 0;
    longint      m_cnt [NS];
    longint      m_hits = 0;
    logic [31:0] m_cap = 32'd0;
    logic [7:0]  m_flags = 8'd0;
    logic [31:0] exp32 = 32'd0, exp8 = 32'd0;

    function automatic longint sat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - longint'(1);
        return (v > mx) ? mx : v;
    endfunction

    function automatic longint lat_now();
        if (m_phase == 1) return cyc - m_start;
        if (m_phase == 2) return m_stop - m_start;
        return longint'(0);
    endfunction

    function automatic logic [31:0] exp_word(input int w, input logic [7:0] s);
        case (s)
            8'd0:  return {16'hDB61, 8'(w), 8'(NS)};
            8'd1:  return {24'd0, m_flags};
            8'd2:  return 32'(sat(lat_now(), w));
            8'd3:  return m_cap;
            8'd4:  return 32'(sat(m_hits, w));
            8'd5:  return 32'(m_phase);
            8'd16, 8'd17, 8'd18, 8'd19: return 32'(sat(m_cnt[s - 8'd16], w));
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    always @(posedge clk) begin
        exp32 = rst ? 32'd0 : exp_word(32, sel_i);
        exp8  = rst ? 32'd0 : exp_word(8, sel_i);
        cyc++;
        if (rst || clr_i) begin
            m_phase = 0;
            m_start = 0;
            m_stop  = 0;
            m_hits  = 0;
            m_cap   = 32'd0;
            m_flags = 8'd0;
            for (int i = 0; i < NS; i++) m_cnt[i] = 0;
        end else begin
            for (int i = 0; i < NS; i++) begin
                if (vld_i[i]) begin
                    m_flags[2*i+1] = 1'b1;
                    m_cnt[i]++;
                end
                if (rdy_i[i]) m_flags[2*i] = 1'b1;
            end
            if (m_phase == 0 && vld_i[0]) begin
                m_start = cyc;
                if (rdy_i[NS-1]) begin
                    m_phase = 2;
                    m_stop  = cyc;
                end else begin
                    m_phase = 1;
                end
            end else if (m_phase == 1 && rdy_i[NS-1]) begin
                m_phase = 2;
                m_stop  = cyc;
            end
            if (cap_en_i && cap_addr_i == match_addr_i) begin
                if (cap_mode_i || m_hits == 0) m_cap = cap_data_i;
                m_hits++;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("dbg_w32",   dbg32, exp32);
            chk("dbg_w8",    dbg8, exp8);
            chk("flags_w32", {24'd0, flags32}, {24'd0, m_flags});
            chk("flags_w8",  {24'd0, flags8}, {24'd0, m_flags});
            chk("busy_w32",  {31'd0, busy32}, {31'd0, m_phase == 1});
            chk("busy_w8",   {31'd0, busy8}, {31'd0, m_phase == 1});
            chk("hit_w32",   {31'd0, hit32}, {31'd0, m_hits != 0});
            chk("hit_w8",    {31'd0, hit8}, {31'd0, m_hits != 0});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr_i = 1'b0; vld_i = 4'd0; rdy_i = 4'd0;
        cap_en_i = 1'b0; cap_mode_i = 1'b0; cap_addr_i = 16'd0;
        cap_data_i = 32'd0; match_addr_i = 16'd43328; sel_i = 8'd0;
        tick();
        tick();
        chk_en = 1'b1;
        rst = 1'b0;
        chk("reset_dbg", dbg32, 32'd0);
        chk("reset_flags", {24'd0, flags32}, 32'd0);

        // ID word and unmapped select
        sel_i = 8'd0; tick();
        chk("id_w32", dbg32, 32'hDB61_2004);
        chk("id_w8", dbg8, 32'hDB61_0804);
        sel_i = 8'd99; tick();
        chk("bad_sel", dbg32, 32'hDEAD_BEEF);

        // Sticky vld flag of stage 1
        sel_i = 8'd1; vld_i = 4'b0010; tick();
        vld_i = 4'd0; tick();
        chk("flag_vld1", dbg32, 32'h0000_0008);
        repeat (3) tick();
        chk("flag_sticky", dbg32, 32'h0000_0008);
        do_clr(); tick();
        chk("flag_cleared", dbg32, 32'd0);

        // Latency of 7 cycles
        sel_i = 8'd2; vld_i = 4'b0001; tick();
        vld_i = 4'd0;
        chk("busy_start", {31'd0, busy32}, 32'd1);
        repeat (6) tick();
        rdy_i = 4'b1000; tick();
        rdy_i = 4'd0;
        chk("busy_end", {31'd0, busy32}, 32'd0);
        tick();
        chk("lat_7", dbg32, 32'd7);
        sel_i = 8'd5; tick();
        chk("state_done", dbg32, 32'd2);

        // Reset mid-measurement, then a fresh 3-cycle measurement
        do_clr();
        vld_i = 4'b0001; tick();
        vld_i = 4'd0; tick();
        rst = 1'b1; tick();
        rst = 1'b0;
        chk("rst_abort_dbg", dbg32, 32'd0);
        chk("rst_abort_busy", {31'd0, busy32}, 32'd0);
        sel_i = 8'd2; vld_i = 4'b0001; tick();
        vld_i = 4'd0; tick(); tick();
        rdy_i = 4'b1000; tick();
        rdy_i = 4'd0; tick();
        chk("lat_3", dbg32, 32'd3);

        // Counter saturation at 8 bits
        do_clr();
        vld_i = 4'b0100;
        repeat (300) tick();
        vld_i = 4'd0; sel_i = 8'd18; tick();
        chk("cnt_sat_w8", dbg8, 32'h0000_00FF);
        chk("cnt_300_w32", dbg32, 32'd300);

        // Capture, first-hit then last-hit mode
        for (int mode = 0; mode < 2; mode++) begin
            do_clr();
            cap_mode_i = mode[0];
            cap_en_i = 1'b1; cap_addr_i = 16'd43328; cap_data_i = 32'd5; tick();
            cap_addr_i = 16'd43329; cap_data_i = 32'd7; tick();
            cap_addr_i = 16'd43328; cap_data_i = 32'd9; tick();
            cap_en_i = 1'b0;
            sel_i = 8'd3; tick();
            chk("cap_data", dbg32, (mode == 0) ? 32'd5 : 32'd9);
            sel_i = 8'd4; tick();
            chk("hit_cnt", dbg32, 32'd2);
        end

        // Clear wins over same-cycle strobe and hit
        clr_i = 1'b1; vld_i = 4'b0001; cap_en_i = 1'b1; tick();
        clr_i = 1'b0; vld_i = 4'd0; cap_en_i = 1'b0;
        chk("clr_hit", {31'd0, hit32}, 32'd0);
        chk("clr_busy", {31'd0, busy32}, 32'd0);
        sel_i = 8'd5; tick();
        chk("clr_state", dbg32, 32'd0);
        sel_i = 8'd16; tick();
        chk("clr_cnt0", dbg32, 32'd0);

        // Mixed traffic checked by the model every cycle
        for (int n = 0; n < 400; n++) begin
            vld_i      = 4'($urandom);
            rdy_i      = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'd0;
            cap_en_i   = 1'($urandom);
            cap_addr_i = 1'($urandom) ? 16'd43328 : 16'($urandom);
            cap_data_i = $urandom;
            cap_mode_i = 1'($urandom);
            sel_i      = ($urandom_range(0, 20) == 20) ? 8'd99 : 8'($urandom_range(0, 19));
            clr_i      = ($urandom_range(0, 63) == 0);
            rst        = ($urandom_range(0, 127) == 0);
            tick();
        end
        rst = 1'b0; clr_i = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
